// File: rtl/instr_loader.sv
// Byte-stream program loader: assembles little-endian 32-bit words, writes them into
// instruction memory and holds the CPU in reset until a full image is in place.
// Optional trailing XOR checksum byte: define INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int BYTE_WIDTH    = 8,
    parameter int DEPTH_WORDS   = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [BYTE_WIDTH-1:0]    byte_i,
    input  logic                     byte_valid_i,
    output logic                     byte_ready_o,
    output logic                     we_o,
    output logic [ADDRESS_WIDTH-1:0] waddr_o,
    output logic [31:0]              wdata_o,
    output logic                     cpu_rst_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam state_t ST_END = ST_CSUM;
`else
    localparam state_t ST_END = ST_DONE;
`endif

    // Running XOR over the data bytes of one image.
    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        csum_next = acc ^ b;
    endfunction

    state_t                   state_r;
    state_t                   state_next_s;
    logic [7:0]               byte_s;
    logic [7:0]               n_lo_r;
    logic [15:0]              n_r;
    logic [15:0]              len_s;
    logic [15:0]              word_idx_r;
    logic [1:0]               lane_r;
    logic [23:0]              asm_r;
    logic                     we_r;
    logic [ADDRESS_WIDTH-1:0] waddr_r;
    logic [31:0]              wdata_r;
    logic                     xfer_s;
    logic                     start_accept_s;
    logic                     words_left_s;
    logic                     ready_s;
    logic                     busy_s;
    logic                     done_s;
    logic                     error_s;
    logic                     cpu_rst_s;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]               csum_r;
`endif

    assign byte_s         = byte_i[7:0];
    assign len_s          = {byte_s, n_lo_r};
    assign xfer_s         = byte_valid_i && ready_s;
    assign words_left_s   = (word_idx_r != n_r);
    assign start_accept_s = start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE) ||
                                        (state_r == ST_ERROR));

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; the final word's write strobe retires DATA so done follows it by a cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    state_next_s = ST_LEN_LO;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_LEN_LO: begin
                if (xfer_s) begin
                    state_next_s = ST_LEN_HI;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_LEN_HI: begin
                if (!xfer_s) begin
                    state_next_s = state_r;
                end else if (len_s == 16'd0) begin
                    state_next_s = ST_END;
                end else if ({1'b0, len_s} > DEPTH_L) begin
                    state_next_s = ST_ERROR;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_DATA: begin
                if (we_r && !words_left_s) begin
                    state_next_s = ST_END;
                end else begin
                    state_next_s = state_r;
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (!xfer_s) begin
                    state_next_s = state_r;
                end else if (byte_s == csum_r) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ERROR;
                end
            end
`endif
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        ready_s   = 1'b0;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        error_s   = 1'b0;
        cpu_rst_s = 1'b1;
        case (state_r)
            ST_LEN_LO, ST_LEN_HI: begin
                ready_s = 1'b1;
                busy_s  = 1'b1;
            end
            ST_DATA: begin
                ready_s = words_left_s;
                busy_s  = 1'b1;
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                ready_s = 1'b1;
                busy_s  = 1'b1;
            end
`endif
            ST_DONE: begin
                done_s    = 1'b1;
                cpu_rst_s = 1'b0;
            end
            ST_ERROR: begin
                error_s = 1'b1;
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    // Datapath: length capture, word assembly in a holding register, write strobe generation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_lo_r     <= 8'd0;
            n_r        <= 16'd0;
            word_idx_r <= 16'd0;
            lane_r     <= 2'd0;
            asm_r      <= 24'd0;
            we_r       <= 1'b0;
            waddr_r    <= '0;
            wdata_r    <= 32'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_r     <= 8'd0;
`endif
        end else begin
            we_r <= 1'b0;
            if (start_accept_s) begin
                word_idx_r <= 16'd0;
                lane_r     <= 2'd0;
                asm_r      <= 24'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                csum_r     <= 8'd0;
`endif
            end else if (xfer_s) begin
                case (state_r)
                    ST_LEN_LO: n_lo_r <= byte_s;
                    ST_LEN_HI: n_r    <= len_s;
                    ST_DATA: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        csum_r <= csum_next(csum_r, byte_s);
`endif
                        lane_r <= lane_r + 2'd1;
                        case (lane_r)
                            2'd0: asm_r[7:0]   <= byte_s;
                            2'd1: asm_r[15:8]  <= byte_s;
                            2'd2: asm_r[23:16] <= byte_s;
                            default: begin
                                we_r       <= 1'b1;
                                wdata_r    <= {byte_s, asm_r};
                                waddr_r    <= ADDRESS_WIDTH'({word_idx_r, 2'b00});
                                word_idx_r <= word_idx_r + 16'd1;
                            end
                        endcase
                    end
                    default: n_lo_r <= n_lo_r;
                endcase
            end
        end
    end

    assign byte_ready_o = ready_s;
    assign busy_o       = busy_s;
    assign done_o       = done_s;
    assign error_o      = error_s;
    assign cpu_rst_o    = cpu_rst_s;
    assign we_o         = we_r;
    assign waddr_o      = waddr_r;
    assign wdata_o      = wdata_r;

endmodule
